lsu: RTL and testbench

//  Load/store unit between EX and MEM. Takes the EX-stage memory request, checks alignment, and drives a

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_load_align.sv | 24 ++
 rtl/lsu.sv | 124 ++++++++++++
 tb/tb_lsu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared widths, funct3 memory opcodes, FSM states and store-path helpers for the LSU
package lsu_pkg;

  localparam int DATA_RANGE        = 32;
  localparam int CORE_MEM_OP_RANGE = 3;

  localparam logic [CORE_MEM_OP_RANGE-1:0] CORE_MEM_OP_B  = 3'b000;
  localparam logic [CORE_MEM_OP_RANGE-1:0] CORE_MEM_OP_H  = 3'b001;
  localparam logic [CORE_MEM_OP_RANGE-1:0] CORE_MEM_OP_W  = 3'b010;
  localparam logic [CORE_MEM_OP_RANGE-1:0] CORE_MEM_OP_BU = 3'b100;
  localparam logic [CORE_MEM_OP_RANGE-1:0] CORE_MEM_OP_HU = 3'b101;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t LSU_IDLE      = 2'd0;
  localparam lsu_state_t LSU_WAIT_DATA = 2'd1;
  localparam lsu_state_t LSU_DRAIN     = 2'd2;

  function automatic logic lsu_misaligned(input logic [CORE_MEM_OP_RANGE-1:0] op,
                                          input logic [1:0] off);
    case (op)
      CORE_MEM_OP_H, CORE_MEM_OP_HU: return off[0];
      CORE_MEM_OP_W:                 return |off;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_byteenable(input logic [CORE_MEM_OP_RANGE-1:0] op,
                                                input logic [1:0] off);
    case (op)
      CORE_MEM_OP_B, CORE_MEM_OP_BU: return 4'b0001 << off;
      CORE_MEM_OP_H, CORE_MEM_OP_HU: return 4'b0011 << off;
      default:                       return 4'b1111;
    endcase
  endfunction

  // Replicating across all lanes lets the slave pick any lane using byteenable alone.
  function automatic logic [DATA_RANGE-1:0] lsu_store_data(input logic [CORE_MEM_OP_RANGE-1:0] op,
                                                           input logic [DATA_RANGE-1:0] wd);
    case (op)
      CORE_MEM_OP_B, CORE_MEM_OP_BU: return {4{wd[7:0]}};
      CORE_MEM_OP_H, CORE_MEM_OP_HU: return {2{wd[15:0]}};
      default:                       return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts the addressed lane down to bit 0 and sign/zero-extends it by load size
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [DATA_RANGE-1:0]        rdata,
  input  logic [1:0]                   off,
  input  logic [CORE_MEM_OP_RANGE-1:0] op,
  output logic [DATA_RANGE-1:0]        data
);

  logic [DATA_RANGE-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (op)
      CORE_MEM_OP_B:  data = {{24{shifted[7]}}, shifted[7:0]};
      CORE_MEM_OP_BU: data = {24'd0, shifted[7:0]};
      CORE_MEM_OP_H:  data = {{16{shifted[15]}}, shifted[15:0]};
      CORE_MEM_OP_HU: data = {16'd0, shifted[15:0]};
      default:        data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: alignment check, single-outstanding data bus master, load return path
module lsu
  import lsu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lsu_mem_read,
  input  logic                         lsu_mem_write,
  input  logic [CORE_MEM_OP_RANGE-1:0] lsu_mem_opcode,
  input  logic [DATA_RANGE-1:0]        lsu_address,
  input  logic [DATA_RANGE-1:0]        lsu_writedata,
  input  logic                         lsu_flush,
  input  logic                         ex_stall_ext,
  output logic                         lsu_exception_load_addr_misaligned,
  output logic                         lsu_exception_store_addr_misaligned,
  output logic                         lsu_stall,
  output logic [DATA_RANGE-1:0]        lsu_readdata,
  output logic                         lsu_readdata_valid,
  output logic                         dbus_read,
  output logic                         dbus_write,
  output logic [DATA_RANGE-1:0]        dbus_address,
  output logic [3:0]                   dbus_byteenable,
  output logic [DATA_RANGE-1:0]        dbus_writedata,
  input  logic                         dbus_waitrequest,
  input  logic [DATA_RANGE-1:0]        dbus_readdata,
  input  logic                         dbus_readdatavalid
);

  lsu_state_t                   state_q, state_d;
  logic                         issued_hold_q, issued_hold_d;
  logic [1:0]                   off_q, off_d;
  logic [CORE_MEM_OP_RANGE-1:0] op_q, op_d;

  logic req;
  logic misaligned;
  logic rd_done;
  logic cmd;
  logic accept;
  logic load_accept;

  assign req        = lsu_mem_read | lsu_mem_write;
  assign misaligned = lsu_misaligned(lsu_mem_opcode, lsu_address[1:0]);
  assign rd_done    = (state_q == LSU_WAIT_DATA) & dbus_readdatavalid & ~rst;

  // A returning load frees the bus in the same cycle, so the next load can go out without a bubble.
  assign cmd = req & ~misaligned & ~lsu_flush & ~issued_hold_q & ~rst &
               ((state_q == LSU_IDLE) | rd_done);

  assign accept      = cmd & ~dbus_waitrequest;
  assign load_accept = accept & lsu_mem_read;

  assign lsu_exception_load_addr_misaligned  = lsu_mem_read & misaligned;
  assign lsu_exception_store_addr_misaligned = lsu_mem_write & ~lsu_mem_read & misaligned;

  assign dbus_read       = cmd & lsu_mem_read;
  assign dbus_write      = cmd & lsu_mem_write & ~lsu_mem_read;
  assign dbus_address    = {lsu_address[31:2], 2'b00};
  assign dbus_byteenable = lsu_byteenable(lsu_mem_opcode, lsu_address[1:0]);
  assign dbus_writedata  = lsu_store_data(lsu_mem_opcode, lsu_writedata);

  assign lsu_readdata_valid = rd_done & ~lsu_flush;

  assign lsu_stall = ~rst & ((cmd & dbus_waitrequest) |
                             ((state_q == LSU_WAIT_DATA) & ~dbus_readdatavalid) |
                             ((state_q == LSU_DRAIN) & req));

  lsu_load_align u_load_align (
    .rdata (dbus_readdata),
    .off   (off_q),
    .op    (op_q),
    .data  (lsu_readdata)
  );

  always_comb begin
    state_d       = state_q;
    issued_hold_d = issued_hold_q;
    off_d         = off_q;
    op_d          = op_q;

    // Held only while the rest of the pipe keeps the accepted instruction parked in EX.
    if (!ex_stall_ext) begin
      issued_hold_d = 1'b0;
    end else if (accept) begin
      issued_hold_d = 1'b1;
    end

    if (load_accept) begin
      off_d = lsu_address[1:0];
      op_d  = lsu_mem_opcode;
    end

    case (state_q)
      LSU_IDLE: begin
        if (load_accept) state_d = LSU_WAIT_DATA;
      end
      LSU_WAIT_DATA: begin
        if (dbus_readdatavalid) begin
          state_d = load_accept ? LSU_WAIT_DATA : LSU_IDLE;
        end else if (lsu_flush) begin
          state_d = LSU_DRAIN;
        end
      end
      LSU_DRAIN: begin
        if (dbus_readdatavalid) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LSU_IDLE;
      issued_hold_q <= 1'b0;
      off_q         <= 2'b00;
      op_q          <= '0;
    end else begin
      state_q       <= state_d;
      issued_hold_q <= issued_hold_d;
      off_q         <= off_d;
      op_q          <= op_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for the load/store unit
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_mem_read;
  logic        lsu_mem_write;
  logic [2:0]  lsu_mem_opcode;
  logic [31:0] lsu_address;
  logic [31:0] lsu_writedata;
  logic        lsu_flush;
  logic        ex_stall_ext;
  logic        lsu_exception_load_addr_misaligned;
  logic        lsu_exception_store_addr_misaligned;
  logic        lsu_stall;
  logic [31:0] lsu_readdata;
  logic        lsu_readdata_valid;
  logic        dbus_read;
  logic        dbus_write;
  logic [31:0] dbus_address;
  logic [3:0]  dbus_byteenable;
  logic [31:0] dbus_writedata;
  logic        dbus_waitrequest;
  logic [31:0] dbus_readdata;
  logic        dbus_readdatavalid;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .lsu_mem_read                        (lsu_mem_read),
    .lsu_mem_write                       (lsu_mem_write),
    .lsu_mem_opcode                      (lsu_mem_opcode),
    .lsu_address                         (lsu_address),
    .lsu_writedata                       (lsu_writedata),
    .lsu_flush                           (lsu_flush),
    .ex_stall_ext                        (ex_stall_ext),
    .lsu_exception_load_addr_misaligned  (lsu_exception_load_addr_misaligned),
    .lsu_exception_store_addr_misaligned (lsu_exception_store_addr_misaligned),
    .lsu_stall                           (lsu_stall),
    .lsu_readdata                        (lsu_readdata),
    .lsu_readdata_valid                  (lsu_readdata_valid),
    .dbus_read                           (dbus_read),
    .dbus_write                          (dbus_write),
    .dbus_address                        (dbus_address),
    .dbus_byteenable                     (dbus_byteenable),
    .dbus_writedata                      (dbus_writedata),
    .dbus_waitrequest                    (dbus_waitrequest),
    .dbus_readdata                       (dbus_readdata),
    .dbus_readdatavalid                  (dbus_readdatavalid)
  );

  task automatic idle_inputs();
    lsu_mem_read       = 1'b0;
    lsu_mem_write      = 1'b0;
    lsu_mem_opcode     = 3'b010;
    lsu_address        = 32'h0;
    lsu_writedata      = 32'h0;
    lsu_flush          = 1'b0;
    ex_stall_ext       = 1'b0;
    dbus_waitrequest   = 1'b0;
    dbus_readdata      = 32'h0;
    dbus_readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    lsu_mem_read = 1'b1; lsu_address = 32'h100; dbus_readdatavalid = 1'b1;
    #1;
    total_cnt++; if (dbus_read !== 1'b0) $display("FAIL rst_dbus_read got %0b exp 0", dbus_read); else pass_cnt++;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL rst_stall got %0b exp 0", lsu_stall); else pass_cnt++;
    total_cnt++; if (lsu_readdata_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", lsu_readdata_valid); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; lsu_mem_read = 1'b0;
    #1;
    total_cnt++; if (lsu_readdata_valid !== 1'b0) $display("FAIL idle_rdv_ignored got %0b exp 0", lsu_readdata_valid); else pass_cnt++;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL idle_stall got %0b exp 0", lsu_stall); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_store_word();
    @(negedge clk);
    lsu_mem_write = 1'b1; lsu_mem_opcode = 3'b010; lsu_address = 32'h100; lsu_writedata = 32'hDEADBEEF;
    #1;
    total_cnt++; if (dbus_write !== 1'b1) $display("FAIL sw_write got %0b exp 1", dbus_write); else pass_cnt++;
    total_cnt++; if (dbus_read !== 1'b0) $display("FAIL sw_read got %0b exp 0", dbus_read); else pass_cnt++;
    total_cnt++; if (dbus_byteenable !== 4'b1111) $display("FAIL sw_be got %b exp 1111", dbus_byteenable); else pass_cnt++;
    total_cnt++; if (dbus_writedata !== 32'hDEADBEEF) $display("FAIL sw_wdata got %h exp deadbeef", dbus_writedata); else pass_cnt++;
    total_cnt++; if (dbus_address !== 32'h100) $display("FAIL sw_addr got %h exp 00000100", dbus_address); else pass_cnt++;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL sw_stall got %0b exp 0", lsu_stall); else pass_cnt++;
    @(negedge clk);
    lsu_mem_write = 1'b0;
    #1;
    total_cnt++; if (dbus_write !== 1'b0) $display("FAIL sw_one_cycle got %0b exp 0", dbus_write); else pass_cnt++;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL sw_after_stall got %0b exp 0", lsu_stall); else pass_cnt++;
  endtask

  task automatic test_store_sub_word();
    @(negedge clk);
    lsu_mem_write = 1'b1; lsu_mem_opcode = 3'b000; lsu_address = 32'h103; lsu_writedata = 32'h000000A5;
    #1;
    total_cnt++; if (dbus_write !== 1'b1) $display("FAIL sb_write got %0b exp 1", dbus_write); else pass_cnt++;
    total_cnt++; if (dbus_byteenable !== 4'b1000) $display("FAIL sb_be got %b exp 1000", dbus_byteenable); else pass_cnt++;
    total_cnt++; if (dbus_writedata !== 32'hA5A5A5A5) $display("FAIL sb_wdata got %h exp a5a5a5a5", dbus_writedata); else pass_cnt++;
    total_cnt++; if (dbus_address !== 32'h100) $display("FAIL sb_addr got %h exp 00000100", dbus_address); else pass_cnt++;
    @(negedge clk);
    lsu_mem_opcode = 3'b001; lsu_address = 32'h102; lsu_writedata = 32'h00001234;
    #1;
    total_cnt++; if (dbus_write !== 1'b1) $display("FAIL sh_write got %0b exp 1", dbus_write); else pass_cnt++;
    total_cnt++; if (dbus_byteenable !== 4'b1100) $display("FAIL sh_be got %b exp 1100", dbus_byteenable); else pass_cnt++;
    total_cnt++; if (dbus_writedata !== 32'h12341234) $display("FAIL sh_wdata got %h exp 12341234", dbus_writedata); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_load_extend();
    logic [2:0]  ops  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b000};
    logic [31:0] adrs [6] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
    logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h80FF7F00, 32'h00007F00, 32'h0000007F};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lsu_mem_read = 1'b1; lsu_mem_opcode = ops[i]; lsu_address = adrs[i];
      #1;
      total_cnt++; if (dbus_read !== 1'b1) $display("FAIL ld%0d_issue got %0b exp 1", i, dbus_read); else pass_cnt++;
      @(negedge clk);
      lsu_mem_read = 1'b0; dbus_readdatavalid = 1'b1; dbus_readdata = 32'h80FF7F00;
      #1;
      total_cnt++; if (lsu_readdata_valid !== 1'b1) $display("FAIL ld%0d_valid got %0b exp 1", i, lsu_readdata_valid); else pass_cnt++;
      total_cnt++; if (lsu_readdata !== exps[i]) $display("FAIL ld%0d_data got %h exp %h", i, lsu_readdata, exps[i]); else pass_cnt++;
      total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL ld%0d_stall got %0b exp 0", i, lsu_stall); else pass_cnt++;
      @(negedge clk);
      dbus_readdatavalid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    lsu_mem_read = 1'b1; lsu_mem_opcode = 3'b100; lsu_address = 32'h102;
    #1;
    total_cnt++; if (dbus_read !== 1'b1) $display("FAIL b2b_first_issue got %0b exp 1", dbus_read); else pass_cnt++;
    @(negedge clk);
    lsu_mem_opcode = 3'b001; lsu_address = 32'h102; dbus_readdatavalid = 1'b1; dbus_readdata = 32'h80FF7F00;
    #1;
    total_cnt++; if (dbus_read !== 1'b1) $display("FAIL b2b_second_issue got %0b exp 1", dbus_read); else pass_cnt++;
    total_cnt++; if (lsu_readdata !== 32'h000000FF) $display("FAIL b2b_first_data got %h exp 000000ff", lsu_readdata); else pass_cnt++;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL b2b_stall got %0b exp 0", lsu_stall); else pass_cnt++;
    @(negedge clk);
    lsu_mem_read = 1'b0;
    #1;
    total_cnt++; if (lsu_readdata_valid !== 1'b1) $display("FAIL b2b_second_valid got %0b exp 1", lsu_readdata_valid); else pass_cnt++;
    total_cnt++; if (lsu_readdata !== 32'hFFFF80FF) $display("FAIL b2b_second_data got %h exp ffff80ff", lsu_readdata); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_wait_and_hold();
    int stall_cnt = 0;
    int acc_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      lsu_mem_read       = (c <= 5);
      lsu_mem_opcode     = 3'b010;
      lsu_address        = 32'h200;
      dbus_waitrequest   = (c < 3);
      ex_stall_ext       = (c >= 3 && c <= 5);
      dbus_readdatavalid = (c == 5);
      dbus_readdata      = 32'hCAFEF00D;
      #1;
      if (lsu_stall) stall_cnt++;
      if (dbus_read && !dbus_waitrequest) acc_cnt++;
      if (c == 5) begin
        total_cnt++; if (lsu_readdata_valid !== 1'b1) $display("FAIL wait_valid got %0b exp 1", lsu_readdata_valid); else pass_cnt++;
        total_cnt++; if (lsu_readdata !== 32'hCAFEF00D) $display("FAIL wait_data got %h exp cafef00d", lsu_readdata); else pass_cnt++;
        total_cnt++; if (dbus_read !== 1'b0) $display("FAIL hold_no_reissue got %0b exp 0", dbus_read); else pass_cnt++;
      end
    end
    total_cnt++; if (stall_cnt !== 4) $display("FAIL wait_stall_cycles got %0d exp 4", stall_cnt); else pass_cnt++;
    total_cnt++; if (acc_cnt !== 1) $display("FAIL wait_reads_accepted got %0d exp 1", acc_cnt); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    lsu_mem_read = 1'b1; lsu_mem_opcode = 3'b001; lsu_address = 32'h101;
    #1;
    total_cnt++; if (lsu_exception_load_addr_misaligned !== 1'b1) $display("FAIL lh_mis_flag got %0b exp 1", lsu_exception_load_addr_misaligned); else pass_cnt++;
    total_cnt++; if (dbus_read !== 1'b0) $display("FAIL lh_mis_read got %0b exp 0", dbus_read); else pass_cnt++;
    total_cnt++; if (lsu_exception_store_addr_misaligned !== 1'b0) $display("FAIL lh_mis_store_flag got %0b exp 0", lsu_exception_store_addr_misaligned); else pass_cnt++;
    @(negedge clk);
    lsu_mem_read = 1'b0; lsu_mem_write = 1'b1; lsu_mem_opcode = 3'b010; lsu_address = 32'h102;
    #1;
    total_cnt++; if (lsu_exception_store_addr_misaligned !== 1'b1) $display("FAIL sw_mis_flag got %0b exp 1", lsu_exception_store_addr_misaligned); else pass_cnt++;
    total_cnt++; if (dbus_write !== 1'b0) $display("FAIL sw_mis_write got %0b exp 0", dbus_write); else pass_cnt++;
    @(negedge clk);
    lsu_mem_write = 1'b0; lsu_mem_read = 1'b1; lsu_mem_opcode = 3'b100; lsu_address = 32'h103;
    #1;
    total_cnt++; if (lsu_exception_load_addr_misaligned !== 1'b0) $display("FAIL lbu_odd_flag got %0b exp 0", lsu_exception_load_addr_misaligned); else pass_cnt++;
    @(negedge clk);
    lsu_mem_read = 1'b0; dbus_readdatavalid = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_flush();
    @(negedge clk);
    lsu_mem_read = 1'b1; lsu_mem_opcode = 3'b010; lsu_address = 32'h300;
    @(negedge clk);
    lsu_flush = 1'b1; lsu_address = 32'h304;
    #1;
    total_cnt++; if (dbus_read !== 1'b0) $display("FAIL flush_no_issue got %0b exp 0", dbus_read); else pass_cnt++;
    @(negedge clk);
    lsu_flush = 1'b0;
    #1;
    total_cnt++; if (lsu_stall !== 1'b1) $display("FAIL drain_stall got %0b exp 1", lsu_stall); else pass_cnt++;
    total_cnt++; if (dbus_read !== 1'b0) $display("FAIL drain_no_issue got %0b exp 0", dbus_read); else pass_cnt++;
    @(negedge clk);
    dbus_readdatavalid = 1'b1; dbus_readdata = 32'hBAD0BAD0;
    #1;
    total_cnt++; if (lsu_readdata_valid !== 1'b0) $display("FAIL drain_discard got %0b exp 0", lsu_readdata_valid); else pass_cnt++;
    @(negedge clk);
    dbus_readdatavalid = 1'b0;
    #1;
    total_cnt++; if (dbus_read !== 1'b1) $display("FAIL after_drain_issue got %0b exp 1", dbus_read); else pass_cnt++;
    total_cnt++; if (dbus_address !== 32'h304) $display("FAIL after_drain_addr got %h exp 00000304", dbus_address); else pass_cnt++;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL after_drain_stall got %0b exp 0", lsu_stall); else pass_cnt++;
    @(negedge clk);
    lsu_mem_read = 1'b0; dbus_readdatavalid = 1'b1; dbus_readdata = 32'h11223344;
    #1;
    total_cnt++; if (lsu_readdata !== 32'h11223344) $display("FAIL after_drain_data got %h exp 11223344", lsu_readdata); else pass_cnt++;
    @(negedge clk);
    lsu_mem_read = 1'b1; lsu_address = 32'h308; dbus_readdatavalid = 1'b0;
    @(negedge clk);
    lsu_mem_read = 1'b0; lsu_flush = 1'b1; dbus_readdatavalid = 1'b1;
    #1;
    total_cnt++; if (lsu_readdata_valid !== 1'b0) $display("FAIL flush_rdv_valid got %0b exp 0", lsu_readdata_valid); else pass_cnt++;
    @(negedge clk);
    lsu_flush = 1'b0; dbus_readdatavalid = 1'b0; lsu_mem_read = 1'b1; lsu_address = 32'h30C;
    #1;
    total_cnt++; if (dbus_read !== 1'b1) $display("FAIL flush_rdv_idle_issue got %0b exp 1", dbus_read); else pass_cnt++;
    @(negedge clk);
    lsu_mem_read = 1'b0; dbus_readdatavalid = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    lsu_mem_read = 1'b1; lsu_mem_opcode = 3'b010; lsu_address = 32'h400;
    @(negedge clk);
    lsu_mem_read = 1'b0;
    #1;
    total_cnt++; if (lsu_stall !== 1'b1) $display("FAIL pre_rst_stall got %0b exp 1", lsu_stall); else pass_cnt++;
    rst = 1'b1; dbus_readdatavalid = 1'b1;
    #1;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL mid_rst_stall got %0b exp 0", lsu_stall); else pass_cnt++;
    total_cnt++; if (lsu_readdata_valid !== 1'b0) $display("FAIL mid_rst_valid got %0b exp 0", lsu_readdata_valid); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (lsu_readdata_valid !== 1'b0) $display("FAIL post_rst_valid got %0b exp 0", lsu_readdata_valid); else pass_cnt++;
    total_cnt++; if (lsu_stall !== 1'b0) $display("FAIL post_rst_stall got %0b exp 0", lsu_stall); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_store_word();
    test_store_sub_word();
    test_load_extend();
    test_back_to_back();
    test_wait_and_hold();
    test_misaligned();
    test_flush();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
